// File: rtl/tlb_pkg.sv
// Shared TLB definitions: op encodings, FSM states, entry layout and CP0 field positions.
package tlb_pkg;

    localparam logic [1:0] OP_TLBP  = 2'd0;
    localparam logic [1:0] OP_TLBR  = 2'd1;
    localparam logic [1:0] OP_TLBWI = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_WB
    } state_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    localparam int EHI_VPN2_LSB = 13;
    localparam int EHI_ASID_LSB = 0;
    localparam int ELO_PFN_LSB  = 6;
    localparam int ELO_C_LSB    = 3;
    localparam int ELO_D_BIT    = 2;
    localparam int ELO_V_BIT    = 1;
    localparam int ELO_G_BIT    = 0;
    localparam int INDEX_P_BIT  = 31;

    localparam logic [31:0] INDEX_P_MASK = 32'h1 << INDEX_P_BIT;

    function automatic logic [31:0] pack_entryhi(input logic [18:0] vpn2, input logic [7:0] asid);
        logic [31:0] w;
        w = '0;
        w[EHI_VPN2_LSB +: 19] = vpn2;
        w[EHI_ASID_LSB +: 8]  = asid;
        return w;
    endfunction

    function automatic logic [31:0] pack_entrylo(input logic [19:0] pfn, input logic [2:0] c,
                                                 input logic d, input logic v, input logic g);
        logic [31:0] w;
        w = '0;
        w[ELO_PFN_LSB +: 20] = pfn;
        w[ELO_C_LSB +: 3]    = c;
        w[ELO_D_BIT]         = d;
        w[ELO_V_BIT]         = v;
        w[ELO_G_BIT]         = g;
        return w;
    endfunction

endpackage

// File: rtl/tlb_match.sv
// Single-entry TLB comparator: VPN2 equal and (global or ASID equal).
module tlb_match
    import tlb_pkg::*;
(
    input  logic [18:0] entry_vpn2_i,
    input  logic [7:0]  entry_asid_i,
    input  logic        entry_g_i,
    input  logic [18:0] vpn2_i,
    input  logic [7:0]  asid_i,
    output logic        hit_o
);

    assign hit_o = (entry_vpn2_i == vpn2_i) && (entry_g_i || (entry_asid_i == asid_i));

endmodule

// File: rtl/tlb_unit.sv
// TLB array with TLBWI/TLBR/TLBP sequencer and a registered lookup port.
// Define TLB_PARALLEL_PROBE_EN for single-cycle TLBP (no SCAN state); default is serial scan.
module tlb_unit
    import tlb_pkg::*;
#(
    parameter int NUM_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [1:0]  op,
    output logic        op_ready,
    output logic        op_done,
    input  logic [18:0] vpn2,
    input  logic [7:0]  asid,
    input  logic [19:0] pfn0,
    input  logic [19:0] pfn1,
    input  logic [2:0]  c0,
    input  logic [2:0]  c1,
    input  logic        d0,
    input  logic        d1,
    input  logic        v0,
    input  logic        v1,
    input  logic        g0,
    input  logic        g1,
    input  logic [30:0] index,
    output logic [3:0]  cp0_wen,
    output logic [31:0] entryhi_wdata,
    output logic [31:0] entrylo0_wdata,
    output logic [31:0] entrylo1_wdata,
    output logic [31:0] indexreg_wdata,
    input  logic        lk_valid,
    input  logic [31:0] lk_vaddr,
    output logic        lk_res_valid,
    output logic        lk_hit,
    output logic        lk_v,
    output logic        lk_d,
    output logic [31:0] lk_paddr
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    state_t            state_q, state_d;
    logic [1:0]        op_q;
    tlb_entry_t        entries_q [NUM_ENTRIES];
    logic [31:0]       entryhi_q, entrylo0_q, entrylo1_q, indexreg_q;
    logic              lk_res_valid_q, lk_hit_q, lk_v_q, lk_d_q;
    logic [31:0]       lk_paddr_q;

    logic              accept;
    logic [IDX_W-1:0]  wr_idx;
    tlb_entry_t        wr_entry, rd_entry;
    logic              unused_index;

    assign accept       = op_valid && (state_q == S_IDLE);
    assign wr_idx       = index[IDX_W-1:0];
    assign rd_entry     = entries_q[wr_idx];
    assign unused_index = ^index[30:IDX_W];

    always_comb begin
        wr_entry      = '0;
        wr_entry.vpn2 = vpn2;
        wr_entry.asid = asid;
        wr_entry.g    = g0 & g1;
        wr_entry.pfn0 = pfn0;
        wr_entry.c0   = c0;
        wr_entry.d0   = d0;
        wr_entry.v0   = v0;
        wr_entry.pfn1 = pfn1;
        wr_entry.c1   = c1;
        wr_entry.d1   = d1;
        wr_entry.v1   = v1;
    end

    // Lookup: all entries compared, lowest matching index selected
    logic [NUM_ENTRIES-1:0] lk_hits;
    logic                   lk_found;
    logic [IDX_W-1:0]       lk_sel;
    logic [19:0]            lk_pfn;
    logic                   lk_pv, lk_pd;

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_lk
        tlb_match u_lk_match (
            .entry_vpn2_i (entries_q[i].vpn2),
            .entry_asid_i (entries_q[i].asid),
            .entry_g_i    (entries_q[i].g),
            .vpn2_i       (lk_vaddr[31:13]),
            .asid_i       (asid),
            .hit_o        (lk_hits[i])
        );
    end

    always_comb begin
        lk_found = 1'b0;
        lk_sel   = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (lk_hits[i] && !lk_found) begin
                lk_found = 1'b1;
                lk_sel   = IDX_W'(i);
            end
        end
        lk_pfn = lk_vaddr[12] ? entries_q[lk_sel].pfn1 : entries_q[lk_sel].pfn0;
        lk_pv  = lk_vaddr[12] ? entries_q[lk_sel].v1   : entries_q[lk_sel].v0;
        lk_pd  = lk_vaddr[12] ? entries_q[lk_sel].d1   : entries_q[lk_sel].d0;
    end

`ifdef TLB_PARALLEL_PROBE_EN
    logic [NUM_ENTRIES-1:0] pr_hits;
    logic                   pr_found;
    logic [IDX_W-1:0]       pr_sel;

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_pr
        tlb_match u_pr_match (
            .entry_vpn2_i (entries_q[i].vpn2),
            .entry_asid_i (entries_q[i].asid),
            .entry_g_i    (entries_q[i].g),
            .vpn2_i       (vpn2),
            .asid_i       (asid),
            .hit_o        (pr_hits[i])
        );
    end

    always_comb begin
        pr_found = 1'b0;
        pr_sel   = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (pr_hits[i] && !pr_found) begin
                pr_found = 1'b1;
                pr_sel   = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] scan_q;
    logic [18:0]      probe_vpn2_q;
    logic [7:0]       probe_asid_q;
    logic             scan_hit;

    tlb_match u_scan_match (
        .entry_vpn2_i (entries_q[scan_q].vpn2),
        .entry_asid_i (entries_q[scan_q].asid),
        .entry_g_i    (entries_q[scan_q].g),
        .vpn2_i       (probe_vpn2_q),
        .asid_i       (probe_asid_q),
        .hit_o        (scan_hit)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef TLB_PARALLEL_PROBE_EN
                    state_d = S_WB;
`else
                    state_d = (op == OP_TLBP) ? S_SCAN : S_WB;
`endif
                end
            end
`ifndef TLB_PARALLEL_PROBE_EN
            S_SCAN: if (scan_hit || (scan_q == LAST_IDX)) state_d = S_WB;
`endif
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_ready = (state_q == S_IDLE);
        op_done  = (state_q == S_WB);
        cp0_wen  = '0;
        if (state_q == S_WB) begin
            case (op_q)
                OP_TLBR: cp0_wen = 4'b1110;
                OP_TLBP: cp0_wen = 4'b0001;
                default: cp0_wen = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q           <= '0;
            entryhi_q      <= '0;
            entrylo0_q     <= '0;
            entrylo1_q     <= '0;
            indexreg_q     <= '0;
            lk_res_valid_q <= 1'b0;
            lk_hit_q       <= 1'b0;
            lk_v_q         <= 1'b0;
            lk_d_q         <= 1'b0;
            lk_paddr_q     <= '0;
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) entries_q[i] <= '0;
`ifndef TLB_PARALLEL_PROBE_EN
            scan_q         <= '0;
            probe_vpn2_q   <= '0;
            probe_asid_q   <= '0;
`endif
        end else begin
            lk_res_valid_q <= lk_valid;
            lk_hit_q       <= lk_valid && lk_found;
            lk_v_q         <= lk_valid && lk_found && lk_pv;
            lk_d_q         <= lk_valid && lk_found && lk_pd;
            lk_paddr_q     <= (lk_valid && lk_found) ? {lk_pfn, lk_vaddr[11:0]} : '0;

            if (accept) begin
                op_q <= op;
                case (op)
                    OP_TLBWI: entries_q[wr_idx] <= wr_entry;
                    OP_TLBR: begin
                        entryhi_q  <= pack_entryhi(rd_entry.vpn2, rd_entry.asid);
                        entrylo0_q <= pack_entrylo(rd_entry.pfn0, rd_entry.c0, rd_entry.d0,
                                                   rd_entry.v0, rd_entry.g);
                        entrylo1_q <= pack_entrylo(rd_entry.pfn1, rd_entry.c1, rd_entry.d1,
                                                   rd_entry.v1, rd_entry.g);
                    end
                    OP_TLBP: begin
`ifdef TLB_PARALLEL_PROBE_EN
                        indexreg_q <= pr_found ? 32'(pr_sel) : INDEX_P_MASK;
`else
                        probe_vpn2_q <= vpn2;
                        probe_asid_q <= asid;
                        scan_q       <= '0;
`endif
                    end
                    default: ;
                endcase
            end

`ifndef TLB_PARALLEL_PROBE_EN
            if (state_q == S_SCAN) begin
                if (scan_hit)                indexreg_q <= 32'(scan_q);
                else if (scan_q == LAST_IDX) indexreg_q <= INDEX_P_MASK;
                scan_q <= scan_q + IDX_W'(1);
            end
`endif
        end
    end

    assign entryhi_wdata  = entryhi_q;
    assign entrylo0_wdata = entrylo0_q;
    assign entrylo1_wdata = entrylo1_q;
    assign indexreg_wdata = indexreg_q;
    assign lk_res_valid   = lk_res_valid_q;
    assign lk_hit         = lk_hit_q;
    assign lk_v           = lk_v_q;
    assign lk_d           = lk_d_q;
    assign lk_paddr       = lk_paddr_q;

endmodule

// File: tb/tb_tlb_unit.sv
// Directed self-checking bench for tlb_unit (default serial-probe build, 16 entries).
module tb_tlb_unit;

    logic        clk, rst;
    logic        op_valid;
    logic [1:0]  op;
    logic        op_ready, op_done;
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic [19:0] pfn0, pfn1;
    logic [2:0]  c0, c1;
    logic        d0, d1, v0, v1, g0, g1;
    logic [30:0] index;
    logic [3:0]  cp0_wen;
    logic [31:0] entryhi_wdata, entrylo0_wdata, entrylo1_wdata, indexreg_wdata;
    logic        lk_valid;
    logic [31:0] lk_vaddr;
    logic        lk_res_valid, lk_hit, lk_v, lk_d;
    logic [31:0] lk_paddr;

    int vectors = 0;
    int miscompares = 0;

    tlb_unit #(.NUM_ENTRIES(16)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .op_ready(op_ready), .op_done(op_done),
        .vpn2(vpn2), .asid(asid), .pfn0(pfn0), .pfn1(pfn1), .c0(c0), .c1(c1),
        .d0(d0), .d1(d1), .v0(v0), .v1(v1), .g0(g0), .g1(g1), .index(index),
        .cp0_wen(cp0_wen), .entryhi_wdata(entryhi_wdata), .entrylo0_wdata(entrylo0_wdata),
        .entrylo1_wdata(entrylo1_wdata), .indexreg_wdata(indexreg_wdata),
        .lk_valid(lk_valid), .lk_vaddr(lk_vaddr), .lk_res_valid(lk_res_valid),
        .lk_hit(lk_hit), .lk_v(lk_v), .lk_d(lk_d), .lk_paddr(lk_paddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op from IDLE; returns cycles from accept edge to the op_done cycle.
    task automatic issue_op(input logic [1:0] o, output int lat);
        int guard;
        guard = 0;
        while (!op_ready && guard < 50) begin tick(); guard++; end
        op_valid = 1'b1;
        op       = o;
        tick();
        op_valid = 1'b0;
        lat      = 1;
        while (!op_done && lat < 40) begin tick(); lat++; end
    endtask

    task automatic test_reset();
        rst = 1'b1; op_valid = 1'b0; op = 2'd0; vpn2 = '0; asid = '0;
        pfn0 = '0; pfn1 = '0; c0 = '0; c1 = '0; d0 = 0; d1 = 0; v0 = 0; v1 = 0; g0 = 0; g1 = 0;
        index = '0; lk_valid = 1'b0; lk_vaddr = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        vectors++; if (op_ready !== 1'b1) begin miscompares++; $display("FAIL reset_op_ready: got %b want 1", op_ready); end
        vectors++; if (op_done !== 1'b0) begin miscompares++; $display("FAIL reset_op_done: got %b want 0", op_done); end
        vectors++; if (cp0_wen !== 4'b0000) begin miscompares++; $display("FAIL reset_cp0_wen: got %b want 0000", cp0_wen); end
        vectors++; if (indexreg_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_indexreg: got %h want 0", indexreg_wdata); end
        vectors++; if ({lk_res_valid, lk_hit, lk_v, lk_d} !== 4'b0000 || lk_paddr !== 32'h0) begin
            miscompares++; $display("FAIL reset_lookup: got %b/%h want 0000/0", {lk_res_valid, lk_hit, lk_v, lk_d}, lk_paddr);
        end
    endtask

    task automatic test_probe_miss();
        int lat;
        vpn2 = 19'h00001; asid = 8'h00;
        issue_op(2'd0, lat);
        vectors++; if (lat !== 17) begin miscompares++; $display("FAIL probe_miss_latency: got %0d want 17", lat); end
        vectors++; if (cp0_wen !== 4'b0001) begin miscompares++; $display("FAIL probe_miss_wen: got %b want 0001", cp0_wen); end
        vectors++; if (indexreg_wdata !== 32'h8000_0000) begin miscompares++; $display("FAIL probe_miss_index: got %h want 80000000", indexreg_wdata); end
        tick();
        vectors++; if (cp0_wen !== 4'b0000 || op_ready !== 1'b1) begin
            miscompares++; $display("FAIL probe_after_wb: got wen=%b ready=%b want 0000/1", cp0_wen, op_ready);
        end
    endtask

    task automatic test_write_probe();
        int lat;
        index = 31'd5; vpn2 = 19'h12345; asid = 8'h03;
        pfn0 = 20'hAAAAA; c0 = 3'd0; d0 = 1'b0; v0 = 1'b1; g0 = 1'b0;
        pfn1 = 20'h55555; c1 = 3'd3; d1 = 1'b1; v1 = 1'b1; g1 = 1'b0;
        issue_op(2'd2, lat);
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL tlbwi_latency: got %0d want 1", lat); end
        vectors++; if (cp0_wen !== 4'b0000) begin miscompares++; $display("FAIL tlbwi_wen: got %b want 0000", cp0_wen); end
        issue_op(2'd0, lat);
        vectors++; if (lat !== 7) begin miscompares++; $display("FAIL probe_hit5_latency: got %0d want 7", lat); end
        vectors++; if (cp0_wen !== 4'b0001) begin miscompares++; $display("FAIL probe_hit5_wen: got %b want 0001", cp0_wen); end
        vectors++; if (indexreg_wdata !== 32'd5) begin miscompares++; $display("FAIL probe_hit5_index: got %h want 5", indexreg_wdata); end
    endtask

    task automatic test_read();
        int lat;
        index = 31'd5; vpn2 = '0; asid = '0; pfn0 = '0; pfn1 = '0; v0 = 0; v1 = 0; d1 = 0; c1 = '0;
        issue_op(2'd1, lat);
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL tlbr_latency: got %0d want 1", lat); end
        vectors++; if (cp0_wen !== 4'b1110) begin miscompares++; $display("FAIL tlbr_wen: got %b want 1110", cp0_wen); end
        vectors++; if (entryhi_wdata !== 32'h2468_A003) begin miscompares++; $display("FAIL tlbr_entryhi: got %h want 2468a003", entryhi_wdata); end
        vectors++; if (entrylo0_wdata !== 32'h02AA_AA82) begin miscompares++; $display("FAIL tlbr_entrylo0: got %h want 02aaaa82", entrylo0_wdata); end
        vectors++; if (entrylo1_wdata !== 32'h0155_555E) begin miscompares++; $display("FAIL tlbr_entrylo1: got %h want 0155555e", entrylo1_wdata); end
        vectors++; if (indexreg_wdata !== 32'd5) begin miscompares++; $display("FAIL tlbr_index_held: got %h want 5", indexreg_wdata); end
        tick();
    endtask

    task automatic test_lookup();
        asid = 8'h03; lk_valid = 1'b1; lk_vaddr = 32'h2468_A123;
        tick();
        vectors++; if ({lk_res_valid, lk_hit, lk_v, lk_d} !== 4'b1110 || lk_paddr !== 32'hAAAA_A123) begin
            miscompares++; $display("FAIL lookup_page0: got %b/%h want 1110/aaaaa123", {lk_res_valid, lk_hit, lk_v, lk_d}, lk_paddr);
        end
        lk_vaddr = 32'h2468_B123;
        tick();
        vectors++; if ({lk_res_valid, lk_hit, lk_v, lk_d} !== 4'b1111 || lk_paddr !== 32'h5555_5123) begin
            miscompares++; $display("FAIL lookup_page1: got %b/%h want 1111/55555123", {lk_res_valid, lk_hit, lk_v, lk_d}, lk_paddr);
        end
        asid = 8'h04; lk_vaddr = 32'h2468_A123;
        tick();
        vectors++; if ({lk_res_valid, lk_hit, lk_v, lk_d} !== 4'b1000 || lk_paddr !== 32'h0) begin
            miscompares++; $display("FAIL lookup_asid_miss: got %b/%h want 1000/0", {lk_res_valid, lk_hit, lk_v, lk_d}, lk_paddr);
        end
        lk_valid = 1'b0;
        tick();
        vectors++; if (lk_res_valid !== 1'b0) begin miscompares++; $display("FAIL lookup_idle_valid: got %b want 0", lk_res_valid); end
    endtask

    task automatic test_back_to_back();
        int lat;
        index = 31'd2; vpn2 = 19'h00ABC; asid = 8'h07;
        pfn0 = 20'h12345; c0 = 3'd0; d0 = 1'b1; v0 = 1'b1; g0 = 1'b1; g1 = 1'b1;
        pfn1 = '0; c1 = '0; d1 = 1'b0; v1 = 1'b0;
        op_valid = 1'b1; op = 2'd2; lk_valid = 1'b1; lk_vaddr = 32'h0157_8456;
        tick();
        op_valid = 1'b0;
        vectors++; if ({lk_res_valid, lk_hit} !== 2'b10 || lk_paddr !== 32'h0) begin
            miscompares++; $display("FAIL same_cycle_old: got %b/%h want 10/0", {lk_res_valid, lk_hit}, lk_paddr);
        end
        vectors++; if (op_done !== 1'b1 || cp0_wen !== 4'b0000) begin
            miscompares++; $display("FAIL same_cycle_wb: got done=%b wen=%b want 1/0000", op_done, cp0_wen);
        end
        asid = 8'h09;
        tick();
        lk_valid = 1'b0;
        vectors++; if ({lk_hit, lk_v, lk_d} !== 3'b111 || lk_paddr !== 32'h1234_5456) begin
            miscompares++; $display("FAIL next_cycle_new: got %b/%h want 111/12345456", {lk_hit, lk_v, lk_d}, lk_paddr);
        end
        index = 31'd9; pfn0 = 20'hFFFFF;
        issue_op(2'd2, lat);
        tick();
        lk_valid = 1'b1;
        tick();
        lk_valid = 1'b0;
        vectors++; if (lk_hit !== 1'b1 || lk_paddr !== 32'h1234_5456) begin
            miscompares++; $display("FAIL lowest_index_wins: got %b/%h want 1/12345456", lk_hit, lk_paddr);
        end
        issue_op(2'd0, lat);
        vectors++; if (lat !== 4 || indexreg_wdata !== 32'd2) begin
            miscompares++; $display("FAIL probe_hit2: got lat=%0d idx=%h want 4/2", lat, indexreg_wdata);
        end
        tick();
    endtask

    task automatic test_reserved_op();
        int lat;
        issue_op(2'd3, lat);
        vectors++; if (lat !== 1 || cp0_wen !== 4'b0000) begin
            miscompares++; $display("FAIL reserved_op: got lat=%0d wen=%b want 1/0000", lat, cp0_wen);
        end
        vectors++; if (entryhi_wdata !== 32'h2468_A003) begin miscompares++; $display("FAIL reserved_entryhi_held: got %h want 2468a003", entryhi_wdata); end
        tick();
    endtask

    task automatic test_reset_mid_scan();
        int seen;
        vpn2 = 19'h7FFFF; asid = 8'h00;
        op_valid = 1'b1; op = 2'd0;
        tick();
        op_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++; if (op_ready !== 1'b1 || op_done !== 1'b0 || cp0_wen !== 4'b0000) begin
            miscompares++; $display("FAIL reset_abort_state: got ready=%b done=%b wen=%b want 1/0/0000", op_ready, op_done, cp0_wen);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (op_done || cp0_wen != 4'b0000) seen++;
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL reset_abort_no_done: got %0d done cycles want 0", seen); end
        asid = 8'h03; lk_valid = 1'b1; lk_vaddr = 32'h2468_A123;
        tick();
        vectors++; if ({lk_res_valid, lk_hit} !== 2'b10 || lk_paddr !== 32'h0) begin
            miscompares++; $display("FAIL reset_cleared_e5: got %b/%h want 10/0", {lk_res_valid, lk_hit}, lk_paddr);
        end
        lk_vaddr = 32'h0157_8456;
        tick();
        lk_valid = 1'b0;
        vectors++; if (lk_hit !== 1'b0 || lk_paddr !== 32'h0) begin
            miscompares++; $display("FAIL reset_cleared_e2: got %b/%h want 0/0", lk_hit, lk_paddr);
        end
    endtask

    initial begin
        test_reset();
        test_probe_miss();
        test_write_probe();
        test_read();
        test_lookup();
        test_back_to_back();
        test_reserved_op();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tlb_unit.md
Name: tlb_unit

Overview:
- TLB array plus a TLB-instruction sequencer: TLBWI, TLBR and TLBP.
- Consumes the field outputs of the CP0 TLB-register block (VPN2, ASID, PFN0/1, C0/1, D0/1, V0/1, G0/1, Index).
- Drives that block's write side (wen[3:0], EntryHi/EntryLo0/EntryLo1/IndexReg write data).
- Also provides one translation lookup port with a 1-cycle registered result for the memory stage.

Parameters:
- NUM_ENTRIES, 16, number of TLB entries; must be a power of two, minimum 2.
- IDX_W, $clog2(NUM_ENTRIES), entry index width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- op_valid  in  1  TLB instruction request.
- op  in  2  request type: 0 = TLBP, 1 = TLBR, 2 = TLBWI; 3 is reserved and treated as a no-op.
- op_ready  out  1  high only in IDLE.
- op_done  out  1  one-cycle completion pulse.
- vpn2  in  19  CP0 EntryHi VPN2 field.
- asid  in  8  CP0 EntryHi ASID field.
- pfn0, pfn1  in  20 each  CP0 EntryLo0/1 PFN fields.
- c0, c1  in  3 each  CP0 EntryLo0/1 C fields.
- d0, d1, v0, v1, g0, g1  in  1 each  CP0 EntryLo0/1 D, V and G bits.
- index  in  31  CP0 Index field; only the low IDX_W bits are used.
- cp0_wen  out  4  write enables: [3] EntryHi, [2] EntryLo0, [1] EntryLo1, [0] IndexReg.
- entryhi_wdata, entrylo0_wdata, entrylo1_wdata, indexreg_wdata  out  32 each  CP0 write data.
- lk_valid  in  1  lookup request.
- lk_vaddr  in  32  virtual address for lookup; the current CP0 asid is used for the ASID compare.
- lk_res_valid  out  1  lookup result valid, one cycle after lk_valid.
- lk_hit, lk_v, lk_d  out  1 each  lookup hit, and V/D bits of the selected page.
- lk_paddr  out  32  physical address {PFN, lk_vaddr[11:0]}.

Behaviour:
- Entry contents: vpn2[18:0], asid[7:0], g, and per page pfn[19:0], c[2:0], d, v.
- Match rule: entry.vpn2 == vpn2 AND (entry.g OR entry.asid == asid).
- Reset: every entry cleared to all-zero (V = 0). FSM returns to IDLE. All outputs 0 except op_ready = 1.
- Reset mid-operation aborts the operation: no op_done and no cp0_wen.
- FSM states: IDLE, SCAN, WB.
- Handshake: an op is accepted when op_valid && op_ready. op and the CP0 inputs are sampled at the accept edge.
- TLBWI: at the accept edge, entry[index[IDX_W-1:0]] is written from the CP0 fields, with g = g0 & g1.
  - Next cycle: op_done = 1, cp0_wen = 0.
  - FSM goes IDLE -> WB -> IDLE.
- TLBR: entry[index] is read at the accept edge. In the WB cycle: op_done = 1, cp0_wen = 4'b1110.
  - entryhi_wdata = {vpn2, 5'b0, asid}.
  - entrylo0_wdata = {6'b0, pfn0, c0, d0, v0, g}; entrylo1_wdata is formed the same way from page 1.
- TLBP (serial): IDLE -> SCAN. One entry is compared per cycle, scan counter running 0..NUM_ENTRIES-1.
  - On the first match, or after the last entry is compared, go to WB.
  - WB cycle: op_done = 1, cp0_wen = 4'b0001.
  - Hit: indexreg_wdata = {1'b0, zero-extended match index}.
  - Miss: indexreg_wdata = 32'h8000_0000 (P bit set).
  - Latency from accept to op_done: k+2 cycles for a hit at entry k; NUM_ENTRIES+1 cycles for a miss.
- op = 3: op_done is pulsed in the next cycle with cp0_wen = 0.
- cp0_wen is 0 in every cycle except the WB cycle. The wdata outputs hold their last value.
- Lookup: combinational compare of all entries against lk_vaddr[31:13], registered into the lk_* outputs.
  - lk_res_valid = lk_valid delayed by one cycle.
  - Page select: lk_vaddr[12] = 0 selects page 0, 1 selects page 1.
  - Multiple matches: the lowest index wins.
  - Miss: lk_hit = 0, lk_paddr = 0, lk_v = 0, lk_d = 0.
- TLBWI and a lookup in the same cycle: the lookup sees the pre-write contents.
- Lookups are serviced in every FSM state.

Optional Feature:
- Macro TLB_PARALLEL_PROBE_EN.
- Defined: TLBP compares all entries in the accept cycle (lowest index wins) and goes directly to WB. The SCAN state and counter are not built. TLBP latency is 1 cycle.
- Undefined: serial scan as specified above.

Decomposition:
- Package tlb_pkg holds:
  - op encoding constants: OP_TLBP, OP_TLBR, OP_TLBWI.
  - FSM state enum.
  - tlb_entry_t struct.
  - CP0 field bit positions (EntryHi VPN2 [31:13], ASID [7:0]; EntryLo PFN [25:6], C [5:3], D [2], V [1], G [0]; Index P bit [31]).
- Sub-module tlb_match: a single-entry comparator taking entry, vpn2 and asid, with output hit. It is instantiated NUM_ENTRIES times for lookup and parallel probe, and once for the serial scan.

Test Plan:
- Reset, then TLBP with vpn2 = 19'h00001 -> miss; op_done at cycle 17 (NUM_ENTRIES = 16); cp0_wen = 4'b0001; indexreg_wdata = 32'h8000_0000.
- TLBWI at index 5 (vpn2 = 19'h12345, asid = 8'h3, pfn0 = 20'hAAAAA, v0 = 1, g0 = g1 = 0), then TLBP with the same fields -> op_done 7 cycles after accept; indexreg_wdata = 5.
- TLBR at index 5 -> next cycle cp0_wen = 4'b1110; entryhi_wdata = {19'h12345, 5'b0, 8'h03}; entrylo0_wdata[25:6] = 20'hAAAAA; entrylo0_wdata[1] = 1.
- Lookup lk_vaddr = 32'h2468_A123 with asid = 3 -> next cycle lk_hit = 1, lk_paddr = 32'hAAAA_A123. Same lookup with asid = 4 and G = 0 -> lk_hit = 0.
- TLBWI to index 2 and a lookup of the same address in the same cycle -> old result. Repeat the lookup next cycle -> new result.
- Assert rst during a TLBP scan -> no op_done; op_ready = 1 the next cycle; all entries invalid (lookup misses).
